dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, word width in bits; it SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_W, default 16, word-address width.
REQ-003 The block SHALL have parameter DEPTH, default 256, number of words; it SHALL satisfy DEPTH <= 2**ADDR_W.
REQ-004 The block SHALL have parameter LAT, default 1, request-to-response latency in cycles; it SHALL lie in the range 1..8.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port req_valid, input, 1 bit: request present.
REQ-008 The block SHALL have port req_ready, output, 1 bit: block can accept a request.
REQ-009 The block SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-010 The block SHALL have port req_be, input, DATA_W/8 bits: byte enables for writes.
REQ-011 The block SHALL have port req_addr, input, ADDR_W bits: word address.
REQ-012 The block SHALL have port req_wdata, input, DATA_W bits: write data.
REQ-013 The block SHALL have port resp_valid, output, 1 bit: one-cycle response strobe.
REQ-014 The block SHALL have port resp_rdata, output, DATA_W bits: read data.
REQ-015 The block SHALL have port resp_err, output, 1 bit: error flag, qualified by resp_valid.

Function
REQ-016 A request SHALL be accepted on a rising edge where req_valid && req_ready.
REQ-017 The block SHALL use three states:
- IDLE: req_ready=1, resp_valid=0.
- WAIT: req_ready=0, resp_valid=0.
- RESP: req_ready=1, resp_valid=1.
REQ-018 On an accept with LAT=1, the next state SHALL be RESP.
REQ-019 On an accept with LAT>1, the next state SHALL be WAIT for exactly LAT-1 cycles, counted by a down-counter, and then RESP.
REQ-020 In RESP, an accept SHALL restart the sequence of REQ-018/019; otherwise the next state SHALL be IDLE.
REQ-021 resp_valid SHALL be high exactly LAT cycles after the accept edge, for exactly one cycle; there is no response backpressure.
REQ-022 Peak throughput SHALL be one request per LAT cycles.
REQ-023 A write SHALL commit at the accept edge, updating only the bytes whose req_be bit is 1.
REQ-024 A request accepted later SHALL observe that write.
REQ-025 A read SHALL register the full word at the captured address on the edge entering RESP.
REQ-026 For a write response, resp_rdata SHALL be 0.
REQ-027 All request fields SHALL be captured at the accept edge; req_* changes after acceptance SHALL have no effect on that request.
REQ-028 An address >= DEPTH SHALL suppress the write, force resp_rdata=0 and set resp_err=1 in its response.
REQ-029 A write with req_be all-zero SHALL leave memory unchanged and give resp_err=0.
REQ-030 When no response is in progress, resp_rdata and resp_err SHALL be 0.

Reset
REQ-031 Assertion of rst_n=0 SHALL immediately force the state to IDLE, the counter to 0, resp_valid=0, resp_rdata=0 and resp_err=0.
REQ-032 During reset, req_ready SHALL be 1.
REQ-033 A reset arriving in WAIT or RESP SHALL drop the pending response; it is never issued.
REQ-034 A write already committed before that reset SHALL remain in memory.
REQ-035 Memory contents SHALL NOT be reset.

Configuration
REQ-036 When macro DMEM_PARITY_EN is defined, the block SHALL store one even-parity bit per byte, written with that byte.
REQ-037 With DMEM_PARITY_EN defined, any parity mismatch on a read SHALL set resp_err=1 while resp_rdata still returns the stored data.
REQ-038 When DMEM_PARITY_EN is undefined, the block SHALL have no parity storage, and resp_err SHALL reflect only out-of-range addresses.

Structure
REQ-039 Package dmem_pkg SHALL hold the state enum typedef (IDLE, WAIT, RESP), the constant LAT_MAX=8, and the counter width derived from LAT_MAX.
REQ-040 Storage SHALL reside in one sub-module, dmem_array: byte-enabled synchronous write, registered read, parity bits under DMEM_PARITY_EN.
REQ-041 The FSM, counter and range check SHALL live in dmem_ctrl.

Verification
REQ-042 Scenario 1: LAT=1, write addr 0x10 data 0xBEEF be=11, then read 0x10 -> resp_valid one cycle after each accept; read returns 0xBEEF; resp_err=0.
REQ-043 Scenario 2: LAT=3, read held valid continuously -> accepts every 3 cycles; req_ready=0 for 2 cycles after each accept.
REQ-044 Scenario 3: after 0xBEEF at 0x10, write 0x1234 be=01, then read -> returns 0xBE34.
REQ-045 Scenario 4: DEPTH=256, write 0x1FF then read 0x1FF -> resp_err=1 and rdata=0 both times; memory at 0xFF unchanged.
REQ-046 Scenario 5: LAT=4, rst_n pulsed low 2 cycles after a read accept -> no resp_valid; req_ready=1 during reset; a prior write persists on re-read.
REQ-047 Scenario 6 (DMEM_PARITY_EN): force-flip one stored bit at 0x20, then read -> resp_err=1 with the corrupted data returned.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
// Contents: state_t FSM encoding, LAT_MAX, CNT_W (latency down-counter width).
package dmem_pkg;

  localparam int unsigned LAT_MAX = 8;
  // The counter holds at most LAT_MAX-1 wait cycles.
  localparam int unsigned CNT_W   = $clog2(LAT_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word storage for dmem_ctrl.
// Byte-enabled synchronous write and a registered read port.
// The read register clears to zero whenever no response is being loaded.
// Optional macro DMEM_PARITY_EN adds one even-parity bit per byte; a parity
// mismatch on a read raises err.
// Ports:
//   clk, rst_n       clock, async active-low reset (read register only)
//   we, be, widx,    write strobe, byte enables, word index, write data
//   wdata
//   ld               load the response register this edge
//   rd_en            the response carries read data (valid in-range read)
//   ridx             read word index
//   err_in           error flag to load alongside the data
//   rdata, err       registered response data and error flag
module dmem_array #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned IDX_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [IDX_W-1:0]      widx,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  ld,
  input  logic                  rd_en,
  input  logic [IDX_W-1:0]      ridx,
  input  logic                  err_in,
  output logic [DATA_W-1:0]     rdata,
  output logic                  err
);

  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              par_bad_c;

  // Byte-enabled write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (be[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

`ifdef DMEM_PARITY_EN
  logic [NB-1:0] par [DEPTH];

  // Even parity per byte, written together with its byte.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (be[b]) par[widx][b] <= ^wdata[b*8 +: 8];
      end
    end
  end

  // Any byte whose recomputed parity disagrees with the stored bit.
  always_comb begin
    par_bad_c = 1'b0;
    for (int b = 0; b < int'(NB); b++) begin
      if ((^mem[ridx][b*8 +: 8]) != par[ridx][b]) par_bad_c = 1'b1;
    end
  end
`else
  assign par_bad_c = 1'b0;
`endif

  // Response register: loaded for one cycle, zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
      err   <= 1'b0;
    end else if (ld) begin
      rdata <= rd_en ? mem[ridx] : '0;
      err   <= err_in | (rd_en & par_bad_c);
    end else begin
      rdata <= '0;
      err   <= 1'b0;
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: single-outstanding request/response front end with
// a fixed request-to-response latency of LAT cycles.
// Optional macro DMEM_PARITY_EN enables per-byte parity in dmem_array.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req_valid / req_ready       request handshake (accept on valid && ready)
//   req_we, req_be, req_addr,   request fields: write flag, byte enables,
//   req_wdata                   word address, write data
//   resp_valid                  one-cycle response strobe
//   resp_rdata, resp_err        response data and error flag (0 when idle)
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned LAT    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_ready_q, resp_valid_q;
  logic               cap_we_q, cap_oor_q;
  logic [IDX_W-1:0]   cap_idx_q;

  logic               accept;
  logic               req_oor;
  logic [IDX_W-1:0]   req_idx;
  logic               enter_resp;
  logic               cur_we, cur_oor;
  logic [IDX_W-1:0]   cur_idx;

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;

  assign accept  = req_valid && req_ready_q;
  assign req_oor = (ADDR_W+1)'(req_addr) >= (ADDR_W+1)'(DEPTH);
  assign req_idx = IDX_W'(req_addr);

  // Next-state and latency counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          if (LAT == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LAT - 1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // With LAT=1 the response is loaded on the accept edge itself, so the live
  // request fields are used; otherwise the captured copy.
  assign enter_resp = (state_d == RESP);
  assign cur_we     = accept ? req_we  : cap_we_q;
  assign cur_oor    = accept ? req_oor : cap_oor_q;
  assign cur_idx    = accept ? req_idx : cap_idx_q;

  // State, registered handshake outputs and request capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      cap_we_q     <= 1'b0;
      cap_oor_q    <= 1'b0;
      cap_idx_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= (state_d != WAIT);
      resp_valid_q <= enter_resp;
      if (accept) begin
        cap_we_q  <= req_we;
        cap_oor_q <= req_oor;
        cap_idx_q <= req_idx;
      end
    end
  end

  // Writes commit at the accept edge; out-of-range writes are dropped.
  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (accept && req_we && !req_oor),
    .be     (req_be),
    .widx   (req_idx),
    .wdata  (req_wdata),
    .ld     (enter_resp),
    .rd_en  (!cur_we && !cur_oor),
    .ridx   (cur_idx),
    .err_in (cur_oor),
    .rdata  (resp_rdata),
    .err    (resp_err)
  );

endmodule

// File: tb/tb_dmem_ctrl.sv
// Testbench for dmem_ctrl: three instances (LAT = 1, 3, 4) sharing clock and
// reset. Table-driven requests push expected responses to a scoreboard that
// is checked every falling edge; hand-written sequences cover throughput,
// reset mid-request and (with DMEM_PARITY_EN) parity corruption.
module tb_dmem_ctrl;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n;

  logic [NI-1:0]        valid, ready, we, rvalid, err;
  logic [NI-1:0][1:0]   be;
  logic [NI-1:0][15:0]  addr, wdata, rdata;

  always #5 clk = ~clk;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 4;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned LAT_G = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    dmem_ctrl #(
      .DATA_W (16),
      .ADDR_W (16),
      .DEPTH  (256),
      .LAT    (LAT_G)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (valid[g]),
      .req_ready  (ready[g]),
      .req_we     (we[g]),
      .req_be     (be[g]),
      .req_addr   (addr[g]),
      .req_wdata  (wdata[g]),
      .resp_valid (rvalid[g]),
      .resp_rdata (rdata[g]),
      .resp_err   (err[g])
    );
  end

  typedef struct {
    int          inst;
    logic        we;
    logic [1:0]  be;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    int          inst;
    logic [15:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];
  vec_t tv[$];
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_err = 0;

  function automatic vec_t mk(input int i, input logic w, input logic [1:0] b,
                              input logic [15:0] a, input logic [15:0] d,
                              input logic [15:0] xr, input logic xe);
    vec_t v;
    v.inst = i; v.we = w; v.be = b; v.addr = a; v.wdata = d;
    v.exp_rdata = xr; v.exp_err = xe;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  // Compare DUT outputs against the scoreboard head.
  task automatic mon();
    for (int i = 0; i < NI; i++) begin
      if (rvalid[i]) begin
        if (sb.size() == 0 || sb[0].inst != i) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_resp inst=%0d cyc=%0d got=1 want=0", i, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk($sformatf("resp_cycle%0d", i), 32'(cyc), 32'(e.due));
          chk($sformatf("resp_rdata%0d", i), 32'(rdata[i]), 32'(e.rdata));
          chk($sformatf("resp_err%0d", i), 32'(err[i]), 32'(e.err));
        end
      end else begin
        chk($sformatf("idle_zero%0d", i), 32'({rdata[i], err[i]}), 32'(0));
      end
    end
    if (sb.size() > 0 && sb[0].due < cyc) begin
      n_chk++;
      n_err++;
      $display("FAIL missed_resp inst=%0d cyc=%0d got=none want_at=%0d", sb[0].inst, cyc, sb[0].due);
      void'(sb.pop_front());
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc++;
    mon();
  endtask

  // Present a request and hold it until accepted; returns accept cycle and
  // the number of cycles spent waiting for ready.
  task automatic issue(input vec_t v, input bit push, output int acc_cyc, output int nrdy);
    int i;
    bit acc;
    i        = v.inst;
    valid[i] = 1'b1;
    we[i]    = v.we;
    be[i]    = v.be;
    addr[i]  = v.addr;
    wdata[i] = v.wdata;
    nrdy     = 0;
    acc_cyc  = -1;
    for (int k = 0; k < 40; k++) begin
      acc = ready[i];
      if (acc && push) sb.push_back('{i, v.exp_rdata, v.exp_err, cyc + lat_of(i)});
      cycle();
      if (acc) begin
        acc_cyc = cyc;
        break;
      end
      nrdy++;
    end
    valid[i] = 1'b0;
    we[i]    = 1'($urandom);
    be[i]    = 2'($urandom);
    addr[i]  = 16'($urandom);
    wdata[i] = 16'($urandom);
    if (acc_cyc < 0) begin
      n_chk++;
      n_err++;
      $display("FAIL accept_timeout inst=%0d got=no_accept want=accept", i);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 20; k++) begin
      if (sb.size() == 0) break;
      cycle();
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain_timeout got=%0d want=0 pending", sb.size());
      sb.delete();
    end
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end

  initial begin
    int ac, nr, prev;
    rst_n = 1'b0;
    valid = '0; we = '0; be = '0; addr = '0; wdata = '0;

    // Reset state.
    cycle();
    cycle();
    chk("reset_ready", 32'(ready), 32'(3'b111));
    chk("reset_rvalid", 32'(rvalid), 32'(0));
    rst_n = 1'b1;
    cycle();
    chk("post_reset_ready", 32'(ready), 32'(3'b111));

    // LAT=1
    tv.push_back(mk(0, 1'b1, 2'b11, 16'h0010, 16'hBEEF, 16'h0000, 1'b0));
    tv.push_back(mk(0, 1'b0, 2'b00, 16'h0010, 16'h0000, 16'hBEEF, 1'b0));
    tv.push_back(mk(0, 1'b1, 2'b01, 16'h0010, 16'h1234, 16'h0000, 1'b0));
    tv.push_back(mk(0, 1'b0, 2'b00, 16'h0010, 16'h0000, 16'hBE34, 1'b0));
    tv.push_back(mk(0, 1'b1, 2'b11, 16'h00FF, 16'hA5A5, 16'h0000, 1'b0));
    tv.push_back(mk(0, 1'b1, 2'b11, 16'h01FF, 16'h5A5A, 16'h0000, 1'b1));
    tv.push_back(mk(0, 1'b0, 2'b00, 16'h01FF, 16'h0000, 16'h0000, 1'b1));
    tv.push_back(mk(0, 1'b0, 2'b00, 16'h00FF, 16'h0000, 16'hA5A5, 1'b0));
    tv.push_back(mk(0, 1'b1, 2'b11, 16'h0100, 16'h0000, 16'h0000, 1'b1));
    tv.push_back(mk(0, 1'b0, 2'b00, 16'h0100, 16'h0000, 16'h0000, 1'b1));
    tv.push_back(mk(0, 1'b1, 2'b00, 16'h0010, 16'hFFFF, 16'h0000, 1'b0));
    tv.push_back(mk(0, 1'b0, 2'b00, 16'h0010, 16'h0000, 16'hBE34, 1'b0));
    tv.push_back(mk(0, 1'b1, 2'b11, 16'h0011, 16'hCAFE, 16'h0000, 1'b0));
    tv.push_back(mk(0, 1'b1, 2'b10, 16'h0011, 16'h7700, 16'h0000, 1'b0));
    tv.push_back(mk(0, 1'b0, 2'b00, 16'h0011, 16'h0000, 16'h77FE, 1'b0));
    tv.push_back(mk(0, 1'b0, 2'b00, 16'hFFFF, 16'h0000, 16'h0000, 1'b1));
    // LAT=3: next request's fields change while the previous one waits.
    tv.push_back(mk(1, 1'b1, 2'b11, 16'h0020, 16'h1111, 16'h0000, 1'b0));
    tv.push_back(mk(1, 1'b1, 2'b11, 16'h0021, 16'h2222, 16'h0000, 1'b0));
    tv.push_back(mk(1, 1'b0, 2'b00, 16'h0020, 16'h0000, 16'h1111, 1'b0));
    tv.push_back(mk(1, 1'b0, 2'b00, 16'h0021, 16'h0000, 16'h2222, 1'b0));
    tv.push_back(mk(1, 1'b1, 2'b01, 16'h0021, 16'h0099, 16'h0000, 1'b0));
    tv.push_back(mk(1, 1'b0, 2'b00, 16'h0021, 16'h0000, 16'h2299, 1'b0));
    tv.push_back(mk(1, 1'b0, 2'b00, 16'h0300, 16'h0000, 16'h0000, 1'b1));
    // LAT=4
    tv.push_back(mk(2, 1'b1, 2'b11, 16'h0030, 16'h4321, 16'h0000, 1'b0));
    tv.push_back(mk(2, 1'b0, 2'b00, 16'h0030, 16'h0000, 16'h4321, 1'b0));

    for (int n = 0; n < tv.size(); n++) begin
      if (n > 0 && tv[n].inst != tv[n-1].inst) drain();
      issue(tv[n], 1'b1, ac, nr);
    end
    drain();

    // Throughput at LAT=3 with a continuously valid read.
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      issue(mk(1, 1'b0, 2'b00, 16'h0020, 16'h0000, 16'h1111, 1'b0), 1'b1, ac, nr);
      if (k > 0) begin
        chk("tp_gap", 32'(ac - prev), 32'(3));
        chk("tp_not_ready", 32'(nr), 32'(2));
      end
      prev = ac;
    end
    drain();

    // Reset two cycles after a LAT=4 read accept: response is dropped.
    issue(mk(2, 1'b0, 2'b00, 16'h0030, 16'h0000, 16'h0000, 1'b0), 1'b0, ac, nr);
    cycle();
    cycle();
    rst_n = 1'b0;
    #1;
    chk("rst_ready_now", 32'(ready), 32'(3'b111));
    chk("rst_rvalid_now", 32'(rvalid), 32'(0));
    cycle();
    chk("rst_ready_hold", 32'(ready), 32'(3'b111));
    cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) cycle();
    issue(mk(2, 1'b0, 2'b00, 16'h0030, 16'h0000, 16'h4321, 1'b0), 1'b1, ac, nr);
    drain();
    issue(mk(0, 1'b0, 2'b00, 16'h0010, 16'h0000, 16'hBE34, 1'b0), 1'b1, ac, nr);
    drain();

`ifdef DMEM_PARITY_EN
    // Flip one stored bit: data comes back corrupted with err set.
    issue(mk(0, 1'b1, 2'b11, 16'h0020, 16'h00F0, 16'h0000, 1'b0), 1'b1, ac, nr);
    drain();
    g_dut[0].u_dut.u_array.mem[32] = g_dut[0].u_dut.u_array.mem[32] ^ 16'h0001;
    issue(mk(0, 1'b0, 2'b00, 16'h0020, 16'h0000, 16'h00F1, 1'b1), 1'b1, ac, nr);
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
